// File: rtl/ber_meter_mc_pkg.sv
// Shared types and width helpers for the multi-channel BER meter.
package ber_meter_mc_pkg;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } lane_state_e;

  // Width of a counter sum with one carry bit, used to detect saturation.
  function automatic int unsigned sum_w(input int unsigned cnt_w);
    return cnt_w + 1;
  endfunction

endpackage

// File: rtl/ber_meter_mc_if.sv
// Symbol/control inputs and per-channel result outputs of the BER meter.
interface ber_meter_mc_if #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned NB_LAT = 5,
  parameter int unsigned NB_CNT = 32
);
  logic                     i_enable;
  logic [N_CH-1:0]          i_rx_bits;
  logic [N_CH-1:0]          i_ref_bits;
  logic                     i_clear;
  logic [N_CH-1:0]          o_lock;
  logic [N_CH*NB_LAT-1:0]   o_lat;
  logic [N_CH*NB_CNT-1:0]   o_err_cnt;
  logic [N_CH*NB_CNT-1:0]   o_bit_cnt;
  logic [N_CH-1:0]          o_sat;

  modport master (
    output i_enable, i_rx_bits, i_ref_bits, i_clear,
    input  o_lock, o_lat, o_err_cnt, o_bit_cnt, o_sat
  );

  modport slave (
    input  i_enable, i_rx_bits, i_ref_bits, i_clear,
    output o_lock, o_lat, o_err_cnt, o_bit_cnt, o_sat
  );
endinterface

// File: rtl/ber_meter_mc_lane.sv
// One BER channel: reference delay line, latency search/lock FSM and
// saturating error/bit accumulators.
module ber_lane
  import ber_meter_mc_pkg::*;
#(
  parameter int unsigned MAX_LAT    = 32,
  parameter int unsigned NB_LAT     = 5,
  parameter int unsigned WIN_LEN    = 511,
  parameter int unsigned NB_WIN     = 9,
  parameter int unsigned LOCK_THR   = 8,
  parameter int unsigned UNLOCK_THR = 64,
  parameter int unsigned NB_CNT     = 32
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_rx_bit,
  input  logic              i_ref_bit,
  input  logic              i_clear,
  output logic              o_lock,
  output logic [NB_LAT-1:0] o_lat,
  output logic [NB_CNT-1:0] o_err_cnt,
  output logic [NB_CNT-1:0] o_bit_cnt,
  output logic              o_sat
);
  localparam int unsigned SUM_W = sum_w(NB_CNT);

  lane_state_e       state_q, state_d;
  logic [MAX_LAT-1:1] dly_q, dly_d;
  logic [MAX_LAT-1:0] taps;
  logic [NB_LAT-1:0] k_q, k_d, best_k_q, best_k_d, lat_q, lat_d;
  logic [NB_WIN-1:0] win_cnt_q, win_cnt_d, win_err_q, win_err_d;
  logic [NB_WIN-1:0] best_q, best_d, win_err_tot;
  logic [NB_CNT-1:0] err_q, err_d, bit_q, bit_d;
  logic              sat_q, sat_d;
  logic              mis, win_end, better;
  logic [SUM_W-1:0]  err_sum, bit_sum;

  // Tap 0 is the live reference bit; tap k is k enabled symbols old.
  assign taps        = {dly_q, i_ref_bit};
  assign mis         = i_rx_bit ^ taps[(state_q == ST_LOCKED) ? lat_q : k_q];
  assign win_end     = (win_cnt_q == NB_WIN'(WIN_LEN - 1));
  assign win_err_tot = win_err_q + NB_WIN'(mis);
  assign better      = (win_err_tot < best_q);
  assign err_sum     = SUM_W'(err_q) + SUM_W'(mis);
  assign bit_sum     = SUM_W'(bit_q) + SUM_W'(1);

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    k_d       = k_q;
    best_d    = best_q;
    best_k_d  = best_k_q;
    lat_d     = lat_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    err_d     = err_q;
    bit_d     = bit_q;
    sat_d     = sat_q;

    if (i_enable) begin
      dly_d = taps[MAX_LAT-2:0];
      if (win_end) begin
        win_cnt_d = '0;
        win_err_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + NB_WIN'(1);
        win_err_d = win_err_tot;
      end

      unique case (state_q)
        ST_SEARCH: begin
          if (win_end) begin
            if (k_q == NB_LAT'(MAX_LAT - 1)) begin
              // Last candidate: fold its window into the running minimum before deciding.
              if (better ? (32'(win_err_tot) < LOCK_THR) : (32'(best_q) < LOCK_THR)) begin
                state_d = ST_LOCKED;
                lat_d   = better ? k_q : best_k_q;
              end
              k_d      = '0;
              best_d   = '1;
              best_k_d = '0;
            end else begin
              k_d = k_q + NB_LAT'(1);
              if (better) begin
                best_d   = win_err_tot;
                best_k_d = k_q;
              end
            end
          end
        end
        ST_LOCKED: begin
          err_d = err_sum[NB_CNT] ? '1 : err_sum[NB_CNT-1:0];
          bit_d = bit_sum[NB_CNT] ? '1 : bit_sum[NB_CNT-1:0];
          sat_d = sat_q | (&err_d) | (&bit_d);
          if (win_end && (32'(win_err_tot) >= UNLOCK_THR)) begin
            state_d = ST_SEARCH;
            k_d     = '0;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    if (i_clear) begin
      err_d = '0;
      bit_d = '0;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_SEARCH;
      dly_q     <= '0;
      k_q       <= '0;
      best_q    <= '1;
      best_k_q  <= '0;
      lat_q     <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      err_q     <= '0;
      bit_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      k_q       <= k_d;
      best_q    <= best_d;
      best_k_q  <= best_k_d;
      lat_q     <= lat_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      err_q     <= err_d;
      bit_q     <= bit_d;
      sat_q     <= sat_d;
    end
  end

  assign o_lock    = (state_q == ST_LOCKED);
  assign o_lat     = lat_q;
  assign o_err_cnt = err_q;
  assign o_bit_cnt = bit_q;
  assign o_sat     = sat_q;

endmodule

// File: rtl/ber_meter_mc.sv
// Multi-channel BER meter top: N_CH independent lanes with packed outputs.
module ber_meter_mc
  import ber_meter_mc_pkg::*;
#(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned MAX_LAT    = 32,
  parameter int unsigned NB_LAT     = 5,
  parameter int unsigned WIN_LEN    = 511,
  parameter int unsigned NB_WIN     = 9,
  parameter int unsigned LOCK_THR   = 8,
  parameter int unsigned UNLOCK_THR = 64,
  parameter int unsigned NB_CNT     = 32
) (
  input logic            clock,
  input logic            i_reset,
  ber_meter_mc_if.slave  bus
);
  logic [N_CH-1:0]        lock_w, sat_w;
  logic [N_CH*NB_LAT-1:0] lat_w;
  logic [N_CH*NB_CNT-1:0] err_w, bit_w;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    ber_lane #(
      .MAX_LAT   (MAX_LAT),
      .NB_LAT    (NB_LAT),
      .WIN_LEN   (WIN_LEN),
      .NB_WIN    (NB_WIN),
      .LOCK_THR  (LOCK_THR),
      .UNLOCK_THR(UNLOCK_THR),
      .NB_CNT    (NB_CNT)
    ) u_lane (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_enable (bus.i_enable),
      .i_rx_bit (bus.i_rx_bits[c]),
      .i_ref_bit(bus.i_ref_bits[c]),
      .i_clear  (bus.i_clear),
      .o_lock   (lock_w[c]),
      .o_lat    (lat_w[c*NB_LAT +: NB_LAT]),
      .o_err_cnt(err_w[c*NB_CNT +: NB_CNT]),
      .o_bit_cnt(bit_w[c*NB_CNT +: NB_CNT]),
      .o_sat    (sat_w[c])
    );
  end

  assign bus.o_lock    = lock_w;
  assign bus.o_lat     = lat_w;
  assign bus.o_err_cnt = err_w;
  assign bus.o_bit_cnt = bit_w;
  assign bus.o_sat     = sat_w;

endmodule

// File: tb/tb_ber_meter_mc.sv
// Randomized-gap bench for ber_meter_mc against a per-channel behavioural model.
module tb_ber_meter_mc;
  localparam int unsigned N_CH       = 2;
  localparam int unsigned MAX_LAT    = 16;
  localparam int unsigned NB_LAT     = 4;
  localparam int unsigned WIN_LEN    = 63;
  localparam int unsigned NB_WIN     = 6;
  localparam int unsigned LOCK_THR   = 8;
  localparam int unsigned UNLOCK_THR = 16;
  localparam int unsigned NB_CNT     = 8;
  localparam int unsigned SWEEP      = MAX_LAT * WIN_LEN;
  localparam int          CMAX       = (1 << NB_CNT) - 1;

  logic clock = 1'b0;
  logic i_reset = 1'b0;
  always #5 clock = ~clock;

  ber_meter_mc_if #(.N_CH(N_CH), .NB_LAT(NB_LAT), .NB_CNT(NB_CNT)) bus ();

  ber_meter_mc #(
    .N_CH(N_CH), .MAX_LAT(MAX_LAT), .NB_LAT(NB_LAT), .WIN_LEN(WIN_LEN),
    .NB_WIN(NB_WIN), .LOCK_THR(LOCK_THR), .UNLOCK_THR(UNLOCK_THR), .NB_CNT(NB_CNT)
  ) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit hist    [N_CH][MAX_LAT];   // hist[c][j]: reference from j+1 enables ago
  bit m_lock  [N_CH];
  int m_k     [N_CH];
  int m_pos   [N_CH];
  int m_win   [N_CH];
  int m_lat   [N_CH];
  int m_err   [N_CH];
  int m_bit   [N_CH];
  bit m_sat   [N_CH];
  int m_sweep [N_CH][MAX_LAT];

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_lock[c] = 0; m_k[c] = 0; m_pos[c] = 0; m_win[c] = 0;
      m_lat[c] = 0; m_err[c] = 0; m_bit[c] = 0; m_sat[c] = 0;
      for (int j = 0; j < MAX_LAT; j++) begin
        hist[c][j] = 0;
        m_sweep[c][j] = 0;
      end
    end
  endtask

  function automatic bit tap(input int c, input int k, input bit r);
    return (k == 0) ? r : hist[c][k-1];
  endfunction

  task automatic model_update(input bit en, input bit clr,
                              input logic [N_CH-1:0] rx, input logic [N_CH-1:0] refv);
    for (int c = 0; c < N_CH; c++) begin
      if (en) begin
        bit mis;
        if (!m_lock[c]) begin
          mis = (rx[c] != tap(c, m_k[c], refv[c]));
          m_win[c] += int'(mis);
          m_pos[c]++;
          if (m_pos[c] == WIN_LEN) begin
            m_sweep[c][m_k[c]] = m_win[c];
            m_win[c] = 0;
            m_pos[c] = 0;
            if (m_k[c] == MAX_LAT - 1) begin
              int best, arg;
              best = m_sweep[c][0];
              arg  = 0;
              for (int k = 1; k < MAX_LAT; k++)
                if (m_sweep[c][k] < best) begin
                  best = m_sweep[c][k];
                  arg  = k;
                end
              if (best < LOCK_THR) begin
                m_lock[c] = 1;
                m_lat[c]  = arg;
              end
              m_k[c] = 0;
            end else begin
              m_k[c]++;
            end
          end
        end else begin
          mis = (rx[c] != tap(c, m_lat[c], refv[c]));
          if (!clr) begin
            if (m_bit[c] < CMAX) m_bit[c]++;
            if (mis && m_err[c] < CMAX) m_err[c]++;
            if (m_bit[c] == CMAX || m_err[c] == CMAX) m_sat[c] = 1;
          end
          m_win[c] += int'(mis);
          m_pos[c]++;
          if (m_pos[c] == WIN_LEN) begin
            if (m_win[c] >= UNLOCK_THR) m_lock[c] = 0;
            m_win[c] = 0;
            m_pos[c] = 0;
          end
        end
        for (int j = MAX_LAT - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
        hist[c][0] = refv[c];
      end
      if (clr) begin
        m_err[c] = 0;
        m_bit[c] = 0;
        m_sat[c] = 0;
      end
    end
  endtask

  // Every falling edge: all outputs against the model.
  always @(negedge clock) begin
    logic [N_CH-1:0]        el, es;
    logic [N_CH*NB_LAT-1:0] elat;
    logic [N_CH*NB_CNT-1:0] ee, eb;
    for (int c = 0; c < N_CH; c++) begin
      el[c] = m_lock[c];
      es[c] = m_sat[c];
      elat[c*NB_LAT +: NB_LAT] = NB_LAT'(m_lat[c]);
      ee[c*NB_CNT +: NB_CNT]   = NB_CNT'(m_err[c]);
      eb[c*NB_CNT +: NB_CNT]   = NB_CNT'(m_bit[c]);
    end
    chk("cyc_lock", 64'(bus.o_lock), 64'(el));
    chk("cyc_lat",  64'(bus.o_lat), 64'(elat));
    chk("cyc_err",  64'(bus.o_err_cnt), 64'(ee));
    chk("cyc_bit",  64'(bus.o_bit_cnt), 64'(eb));
    chk("cyc_sat",  64'(bus.o_sat), 64'(es));
  end

  // ---------------- stimulus ----------------
  logic [8:0] prbs [N_CH];
  bit         sh   [N_CH][32];
  int         dly  [N_CH];
  bit         rnd_rx [N_CH];
  bit         inj = 0;
  int         inj_cnt = 0;

  task automatic cycle(input bit en, input bit clr);
    logic [N_CH-1:0] refv, rxv;
    @(negedge clock);
    #2;
    for (int c = 0; c < N_CH; c++) begin
      refv[c] = prbs[c][8];
      if (rnd_rx[c]) rxv[c] = 1'($urandom);
      else           rxv[c] = (dly[c] == 0) ? refv[c] : sh[c][dly[c]-1];
    end
    if (inj && en) begin
      inj_cnt++;
      if (inj_cnt % 100 == 0) rxv[0] = ~rxv[0];
    end
    bus.i_enable   = en;
    bus.i_clear    = clr;
    bus.i_ref_bits = refv;
    bus.i_rx_bits  = rxv;
    @(posedge clock);
    model_update(en, clr, rxv, refv);
    if (en) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int j = 31; j > 0; j--) sh[c][j] = sh[c][j-1];
        sh[c][0] = refv[c];
        prbs[c] = {prbs[c][7:0], prbs[c][8] ^ prbs[c][4]};
      end
    end
  endtask

  task automatic run_en(input int n);
    int done = 0;
    while (done < n) begin
      bit en = ($urandom_range(3) != 0);
      cycle(en, 1'b0);
      done += int'(en);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    #2;
    bus.i_enable = 1'b0;
    bus.i_clear  = 1'b0;
    i_reset      = 1'b0;
    model_reset();
    #1;
    chk("rst_lock", 64'(bus.o_lock), 64'd0);
    chk("rst_lat",  64'(bus.o_lat), 64'd0);
    chk("rst_err",  64'(bus.o_err_cnt), 64'd0);
    chk("rst_bit",  64'(bus.o_bit_cnt), 64'd0);
    chk("rst_sat",  64'(bus.o_sat), 64'd0);
    @(negedge clock);
    #2;
    i_reset = 1'b1;
  endtask

  task automatic wait_drop0(input string name);
    int i = 0;
    while (bus.o_lock[0] && i < 2 * int'(WIN_LEN)) begin
      run_en(1);
      #1;
      i++;
    end
    chk(name, 64'(bus.o_lock[0]), 64'd0);
  endtask

  initial begin
    bus.i_enable = 1'b0; bus.i_clear = 1'b0; bus.i_rx_bits = '0; bus.i_ref_bits = '0;
    prbs[0] = 9'h1FF; prbs[1] = 9'h0A5;
    dly[0] = 7; dly[1] = 3;
    rnd_rx[0] = 0; rnd_rx[1] = 0;
    for (int c = 0; c < N_CH; c++) for (int j = 0; j < 32; j++) sh[c][j] = 0;
    model_reset();
    repeat (3) @(negedge clock);
    #2;
    i_reset = 1'b1;

    // Clean lock on both channels
    run_en(SWEEP - 1); #1;
    chk("prelock", 64'(bus.o_lock), 64'd0);
    run_en(1); #1;
    chk("lock_both", 64'(bus.o_lock), 64'h3);
    chk("lat_both",  64'(bus.o_lat), 64'h37);
    chk("err_clean", 64'(bus.o_err_cnt), 64'd0);
    run_en(50); #1;
    chk("bits50", 64'(bus.o_bit_cnt), 64'h3232);

    // Error injection: every 100th ch0 bit flipped over 10000 enables
    cycle(1'b0, 1'b1);
    inj = 1; inj_cnt = 0;
    run_en(10000);
    inj = 0; #1;
    chk("inj_err0",  64'(bus.o_err_cnt[NB_CNT-1:0]), 64'd100);
    chk("inj_bit0",  64'(bus.o_bit_cnt[NB_CNT-1:0]), 64'd255);
    chk("inj_lock0", 64'(bus.o_lock[0]), 64'd1);
    chk("inj_sat0",  64'(bus.o_sat[0]), 64'd1);

    // Relock after latency change
    dly[0] = 12;
    wait_drop0("relock_drop");
    run_en(SWEEP - 1); #1;
    chk("relock_pre", 64'(bus.o_lock[0]), 64'd0);
    run_en(1); #1;
    chk("relock_lock", 64'(bus.o_lock[0]), 64'd1);
    chk("relock_lat",  64'(bus.o_lat[NB_LAT-1:0]), 64'd12);

    // No lock with uncorrelated rx on ch0
    rnd_rx[0] = 1;
    wait_drop0("nolock_drop");
    cycle(1'b0, 1'b1);
    for (int s = 0; s < 3; s++) begin
      run_en(SWEEP); #1;
      chk("nolock_lock", 64'(bus.o_lock[0]), 64'd0);
      chk("nolock_err",  64'(bus.o_err_cnt[NB_CNT-1:0]), 64'd0);
      chk("nolock_bit",  64'(bus.o_bit_cnt[NB_CNT-1:0]), 64'd0);
    end

    // Saturation and clear-with-enable
    rnd_rx[0] = 0; dly[0] = 7;
    run_en(SWEEP); #1;
    chk("sat_lock", 64'(bus.o_lock[0]), 64'd1);
    chk("sat_lat",  64'(bus.o_lat[NB_LAT-1:0]), 64'd7);
    cycle(1'b0, 1'b1);
    run_en(300); #1;
    chk("sat_bit", 64'(bus.o_bit_cnt[NB_CNT-1:0]), 64'd255);
    chk("sat_flag", 64'(bus.o_sat[0]), 64'd1);
    cycle(1'b1, 1'b1); #1;
    chk("clr_bit",  64'(bus.o_bit_cnt[NB_CNT-1:0]), 64'd0);
    chk("clr_err",  64'(bus.o_err_cnt[NB_CNT-1:0]), 64'd0);
    chk("clr_sat",  64'(bus.o_sat[0]), 64'd0);
    chk("clr_lock", 64'(bus.o_lock[0]), 64'd1);
    run_en(1); #1;
    chk("clr_next", 64'(bus.o_bit_cnt[NB_CNT-1:0]), 64'd1);

    // Reset midway through candidate k=15
    pulse_reset();
    run_en(15 * WIN_LEN + WIN_LEN / 2);
    pulse_reset();
    run_en(SWEEP - 1); #1;
    chk("rst_prelock", 64'(bus.o_lock), 64'd0);
    run_en(1); #1;
    chk("rst_lock_both", 64'(bus.o_lock), 64'h3);
    chk("rst_lat_both",  64'(bus.o_lat), 64'h37);

    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
